sdram_port_arb: RTL

Three-client arbiter that shares one toggle-handshake SDRAM request port (req/ack/we/a/ds/d/q) between independent requesters such as the ROM downloader, the sprite fetcher and the CPU-side cache. Each client sees its own copy of the same toggle handshake. The arbiter grants one transaction at a time in round-robin order, forwards it to the SDRAM controller port, and returns read data to the owner. A watchdog completes stuck transactions and flags an error.

---
 rtl/sdram_port_if.sv | 21 ++
 rtl/sdram_port_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sdram_port_if.sv
// Toggle-handshake command port between the arbiter (master)
// and the SDRAM controller (slave).
interface sdram_port_if;
  logic        req;
  logic        ack;
  logic        we;
  logic [23:1] a;
  logic [1:0]  ds;
  logic [15:0] d;
  logic [15:0] q;

  modport master (
    output req, we, a, ds, d,
    input  ack, q
  );

  modport slave (
    input  req, we, a, ds, d,
    output ack, q
  );
endinterface

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM port
// between three clients, with a watchdog on stuck transactions.
module sdram_port_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c0_req,
  input  logic         c0_we,
  input  logic [23:1]  c0_a,
  input  logic [1:0]   c0_ds,
  input  logic [15:0]  c0_d,
  output logic         c0_ack,
  output logic [15:0]  c0_q,
  input  logic         c1_req,
  input  logic         c1_we,
  input  logic [23:1]  c1_a,
  input  logic [1:0]   c1_ds,
  input  logic [15:0]  c1_d,
  output logic         c1_ack,
  output logic [15:0]  c1_q,
  input  logic         c2_req,
  input  logic         c2_we,
  input  logic [23:1]  c2_a,
  input  logic [1:0]   c2_ds,
  input  logic [15:0]  c2_d,
  output logic         c2_ack,
  output logic [15:0]  c2_q,
  sdram_port_if.master port,
  output logic         err,
  output logic         busy
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  grant;
  logic [1:0]  rr;
  logic [1:0]  p1;
  logic [1:0]  p2;
  logic [1:0]  pick;
  logic [15:0] wdog;
  logic [2:0]  ack;
  logic [2:0]  pend;
  logic        found;
  logic        done;
  logic        tmo;
  logic        sel_we;
  logic [23:1] sel_a;
  logic [1:0]  sel_ds;
  logic [15:0] sel_d;
  logic [15:0] rd_data;

  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign pend   = {c2_req, c1_req, c0_req} ^ ack;
  assign p1     = nxt(rr);
  assign p2     = nxt(p1);
  assign c0_ack = ack[0];
  assign c1_ack = ack[1];
  assign c2_ack = ack[2];

  always_comb begin
    found = 1'b1;
    pick  = rr;
    if (pend[rr])      pick = rr;
    else if (pend[p1]) pick = p1;
    else if (pend[p2]) pick = p2;
    else               found = 1'b0;
  end

  always_comb begin
    sel_we = c0_we;
    sel_a  = c0_a;
    sel_ds = c0_ds;
    sel_d  = c0_d;
    unique case (pick)
      2'd1: begin
        sel_we = c1_we;
        sel_a  = c1_a;
        sel_ds = c1_ds;
        sel_d  = c1_d;
      end
      2'd2: begin
        sel_we = c2_we;
        sel_a  = c2_a;
        sel_ds = c2_ds;
        sel_d  = c2_d;
      end
      default: ;
    endcase
  end

  // A timed-out read returns all ones so the owner can spot it
  assign done    = (port.ack == port.req);
  assign tmo     = !done && (wdog == WD_LAST);
  assign rd_data = done ? port.q : 16'hFFFF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 2'd0;
      rr       <= 2'd0;
      wdog     <= 16'd0;
      ack      <= 3'd0;
      c0_q     <= 16'd0;
      c1_q     <= 16'd0;
      c2_q     <= 16'd0;
      port.req <= 1'b0;
      port.we  <= 1'b0;
      port.a   <= '0;
      port.ds  <= 2'd0;
      port.d   <= 16'd0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant    <= pick;
            port.we  <= sel_we;
            port.a   <= sel_a;
            port.ds  <= sel_ds;
            port.d   <= sel_d;
            port.req <= ~port.req;
            wdog     <= 16'd0;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (done || tmo) begin
            if (!port.we) begin
              unique case (grant)
                2'd1:    c1_q <= rd_data;
                2'd2:    c2_q <= rd_data;
                default: c0_q <= rd_data;
              endcase
            end
            ack[grant] <= ~ack[grant];
            rr         <= nxt(grant);
            busy       <= 1'b0;
            state      <= IDLE;
            if (tmo) begin
              err      <= 1'b1;
              port.req <= port.ack;
            end
          end else if (wdog != 16'hFFFF) begin
            wdog <= wdog + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
